lcd_status_text: RTL
====================

Name: lcd_status_text

Overview:
- Upstream feeder for the two-line LCD writer. Formats live audio-effector status into the two 16-character ASCII lines the writer consumes.
- Line 0 carries the volume value and the effect name. Line 1 carries the peak value and a bar graph.
- Binary-to-decimal conversion is iterative (double dabble). One shared converter handles both values in sequence.
- The outputs hold the previous text until a new, complete frame is ready, so the writer never displays a half-updated line.

Parameters:
- BAR_SHIFT, 13, right-shift applied to iValue1 to get the bar length before saturation.
- BAR_MAX, 6, maximum number of '#' characters in the bar.

Ports:
- iCLK_50  in  1  50 MHz system clock; only clock in the block.
- iRST_N  in  1  reset; asynchronous, active-low.
- iUpdate  in  1  single-cycle request to re-render the text.
- iValue0  in  16  unsigned volume value.
- iValue1  in  16  unsigned peak value.
- iMode  in  2  effect select: 0 BYPASS, 1 ECHO, 2 DIST, 3 REVERB.
- oString0  out  [0:15][7:0]  line-0 ASCII; element 0 is the leftmost character.
- oString1  out  [0:15][7:0]  line-1 ASCII.
- oBusy  out  1  high while a frame is being rendered.
- oValid  out  1  one-cycle pulse when both strings have just been updated.

Behaviour:
- Reset (asynchronous, while iRST_N=0):
  - Every byte of oString0 and oString1 is 8'h20 (space).
  - oBusy=0, oValid=0, pending=0.
  - FSM goes to IDLE and the converter is cleared.
  - Reset in the middle of a conversion aborts it; no partial text is ever written.
- FSM states: IDLE -> CONV0 -> CONV1 -> PACK -> IDLE.
- IDLE:
  - On an edge where iUpdate=1 or pending=1: capture iValue0, iValue1 and iMode into internal registers, clear pending, go to CONV0.
  - Call this capture edge k.
- CONV0: the converter runs 16 shift/add-3 iterations on the captured iValue0 (edges k+1..k+16), producing 5 BCD digits, then go to CONV1.
- CONV1: the same 16 iterations on the captured iValue1 (edges k+17..k+32), then go to PACK.
- PACK: at edge k+33, assemble both lines.
- Output update: at edge k+34, oString0 and oString1 load together, oValid goes to 1 for exactly one cycle, and the FSM returns to IDLE.
  - Latency from the capture edge to valid strings is 34 cycles.
- oBusy=1 whenever the state is not IDLE, i.e. from after edge k until after edge k+34.
- Line 0 layout:
  - chars 0-3: "VOL ".
  - chars 4-8: volume digits, right-aligned.
  - char 9: space.
  - chars 10-15: mode name padded to 6 characters: "BYPASS", "ECHO  ", "DIST  ", "REVERB".
- Line 1 layout:
  - chars 0-3: "PEAK".
  - chars 4-8: peak digits, right-aligned.
  - char 9: space.
  - chars 10-15: bar graph, left-aligned. n = min(iValue1 >> BAR_SHIFT, BAR_MAX) characters are '#' (8'h23); the rest are spaces.
- Digits:
  - Each digit is output as 8'h30 + BCD value.
  - Leading zeros are blanked to spaces; the ones digit is never blanked, so 0 renders as "    0".
  - Full range 0..65535 fits in 5 digits; no overflow is possible.
- iUpdate while oBusy=1: sets pending; multiple requests coalesce into one.
  - At the edge that returns to IDLE nothing is captured.
  - With pending set, the next edge (k+35) captures fresh inputs and starts a new frame.
- iUpdate asserted on the same edge the FSM enters IDLE is treated as a busy-time request, i.e. it sets pending.
- Input changes during a conversion have no effect on the frame in progress.

Decomposition:
- Package lcd_text_pkg holds:
  - the FSM state enum typedef;
  - a line typedef, [0:15][7:0];
  - ASCII constants: space, '0', '#';
  - the 4x6-character mode-name table;
  - the label constants "VOL " and "PEAK".
- Sub-module bin2bcd_seq:
  - 16-bit to 5-digit iterative double dabble.
  - Start/done handshake; fixed 16-iteration run.
  - Instantiated once and reused for both values.
- Leading-zero blanking and line assembly stay in the top-level block.

Test Plan:
- Reset: assert iRST_N=0 mid-run -> both strings are all 8'h20, oBusy=0, oValid=0 immediately (asynchronous); no oValid pulse follows.
- Zero frame: iValue0=0, iValue1=0, iMode=0, pulse iUpdate -> oValid exactly 34 cycles after the capture edge; oString0="VOL     0 BYPASS", oString1="PEAK    0       ".
- Max frame: iValue0=65535, iValue1=16'hFFFF, iMode=3 -> "VOL 65535 REVERB" and "PEAK65535 ######" (bar saturates at 6).
- Mid values: iValue0=1007, iValue1=16'h4000, iMode=1 -> "VOL  1007 ECHO  " and "PEAK16384 ##    ".
- Busy coalescing: pulse iUpdate three times during CONV0 with values changed after capture -> the first frame shows the captured values; exactly one further frame starts at k+35 with the new values; exactly two oValid pulses in total.
- Hold: change inputs without iUpdate -> strings unchanged and oBusy stays 0 for 100 cycles.

Source files
------------

// File: rtl/lcd_text_pkg.sv
// Shared types and constants for the LCD status-text formatter.
// Text is packed leftmost-character-first: element 0 is the MSB byte.
package lcd_text_pkg;

   typedef enum logic [1:0] {IDLE, CONV0, CONV1, PACK} state_t;

   typedef logic [0:15][7:0] line_t;

   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_HASH  = 8'h23;

   localparam logic [31:0] LBL_VOL  = "VOL ";
   localparam logic [31:0] LBL_PEAK = "PEAK";

   // Indexed by iMode; every name is padded to 6 characters.
   localparam logic [0:3][47:0] MODE_NAMES = {"BYPASS", "ECHO  ", "DIST  ", "REVERB"};

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 16-bit to 5-digit BCD converter (double dabble), one bit per cycle.
// done is high during the 16th iteration; bcd then shows the finished result.
module bin2bcd_seq (
   input  logic        iCLK_50,
   input  logic        iRST_N,
   input  logic        start,
   input  logic [15:0] din,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] binReg;
   logic [19:0] bcdReg, adj;
   logic [3:0]  cnt;
   logic        running;

   always_comb begin
      adj = bcdReg;
      for (int i = 0; i < 5; i++)
         if (bcdReg[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcdReg[i*4 +: 4] + 4'd3;
   end

   // Combinational next value, so the caller can latch it on the final edge.
   assign bcd  = {adj[18:0], binReg[15]};
   assign done = running && (cnt == 4'd15);

   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         binReg  <= '0;
         bcdReg  <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         binReg  <= din;
         bcdReg  <= '0;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         binReg  <= binReg << 1;
         bcdReg  <= bcd;
         cnt     <= cnt + 4'd1;
         if (cnt == 4'd15) running <= 1'b0;
      end
   end

endmodule

// File: rtl/lcd_status_text.sv
// Renders volume/mode and peak/bar-graph into two 16-char LCD lines.
// Outputs change only as a whole frame, 34 cycles after the capture edge.
module lcd_status_text
   import lcd_text_pkg::*;
#(
   parameter int BAR_SHIFT = 13,
   parameter int BAR_MAX   = 6
) (
   input  logic             iCLK_50,
   input  logic             iRST_N,
   input  logic             iUpdate,
   input  logic [15:0]      iValue0,
   input  logic [15:0]      iValue1,
   input  logic [1:0]       iMode,
   output logic [0:15][7:0] oString0,
   output logic [0:15][7:0] oString1,
   output logic             oBusy,
   output logic             oValid
);

   state_t      state, nextState;
   logic        pending, staged, take;
   logic [15:0] val1, barRaw;
   logic [1:0]  mode;
   logic [19:0] digits0, digits1, convBcd;
   logic        convStart, convDone;
   line_t       stage0, stage1, line0, line1;
   logic [0:5][7:0] bar;

   function automatic logic [39:0] digitsText(input logic [19:0] d);
      logic lead;
      logic [3:0] nib;
      logic [39:0] t;
      lead = 1'b1;
      t    = '0;
      for (int i = 4; i >= 0; i--) begin
         nib = d[i*4 +: 4];
         if (lead && nib == 4'd0 && i != 0) t[i*8 +: 8] = ASC_SPACE;
         else begin
            lead = 1'b0;
            t[i*8 +: 8] = ASC_ZERO + {4'd0, nib};
         end
      end
      return t;
   endfunction

   assign take      = (state == IDLE) && (iUpdate || pending);
   // The capture edge also loads the converter with iValue0 directly.
   assign convStart = take || (state == CONV0 && convDone);

   bin2bcd_seq uConv (
      .iCLK_50 (iCLK_50),
      .iRST_N  (iRST_N),
      .start   (convStart),
      .din     ((state == IDLE) ? iValue0 : val1),
      .done    (convDone),
      .bcd     (convBcd)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (take)     nextState = CONV0;
         CONV0: if (convDone) nextState = CONV1;
         CONV1: if (convDone) nextState = PACK;
         PACK:  if (staged)   nextState = IDLE;
         default:             nextState = IDLE;
      endcase
   end

   assign barRaw = val1 >> BAR_SHIFT;

   always_comb begin
      for (int i = 0; i < 6; i++)
         bar[i] = (i < BAR_MAX && barRaw > 16'(i)) ? ASC_HASH : ASC_SPACE;
      line0 = {LBL_VOL,  digitsText(digits0), ASC_SPACE, MODE_NAMES[mode]};
      line1 = {LBL_PEAK, digitsText(digits1), ASC_SPACE, bar};
   end

   assign oBusy = (state != IDLE);

   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= IDLE;
         pending  <= 1'b0;
         staged   <= 1'b0;
         val1     <= '0;
         mode     <= '0;
         digits0  <= '0;
         digits1  <= '0;
         stage0   <= {16{ASC_SPACE}};
         stage1   <= {16{ASC_SPACE}};
         oString0 <= {16{ASC_SPACE}};
         oString1 <= {16{ASC_SPACE}};
         oValid   <= 1'b0;
      end else begin
         state  <= nextState;
         oValid <= 1'b0;
         if (take) begin
            pending <= 1'b0;
            val1    <= iValue1;
            mode    <= iMode;
         end else if (state != IDLE && iUpdate) begin
            pending <= 1'b1;
         end
         if (state == CONV0 && convDone) digits0 <= convBcd;
         if (state == CONV1 && convDone) digits1 <= convBcd;
         if (state == PACK) begin
            if (!staged) begin
               stage0 <= line0;
               stage1 <= line1;
               staged <= 1'b1;
            end else begin
               oString0 <= stage0;
               oString1 <= stage1;
               oValid   <= 1'b1;
               staged   <= 1'b0;
            end
         end
      end
   end

endmodule
